// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one send/busy UART byte transmitter
// Packet locking with timeout is built only when UART_ARB_PKTLOCK_EN is defined.

module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int GAP_CYCLES   = 0,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic              clk100,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              ser_busy,
  output logic [7:0]        ser_sbyte,
  output logic              ser_send,
  output logic [1:0]        grant_id,
  output logic              active
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } state_t;

  localparam logic [1:0]  GRANT_RST = 2'(NREQ - 1);
  localparam logic [15:0] GAP_LAST  = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t          state;
  state_t          state_next;
  logic [NREQ-1:0] eligible;
  logic            win_found;
  logic [1:0]      win_idx;
  logic [1:0]      cand;
  logic            take;
  logic [15:0]     gap_cnt;

`ifdef UART_ARB_PKTLOCK_EN
  localparam int           LW       = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_TIMEOUT);

  logic          locked;
  logic [1:0]    lock_id;
  logic [LW-1:0] lock_cnt;
  logic          lock_hold;

  // Lock stays effective until the idle-time counter saturates at LOCK_TIMEOUT.
  assign lock_hold = locked && (lock_cnt != LOCK_MAX);
  assign eligible  = lock_hold ? (req_valid & (NREQ'(1) << lock_id)) : req_valid;

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      locked   <= 1'b0;
      lock_id  <= '0;
      lock_cnt <= '0;
    end else if (take) begin
      locked   <= !req_last[win_idx];
      lock_id  <= win_idx;
      lock_cnt <= '0;
    end else if (state == ST_IDLE && locked && !req_valid[lock_id] && lock_cnt != LOCK_MAX) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  // Search starts one past the last grant and wraps modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = grant_id;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 2'((int'(grant_id) + k) % NREQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign take = (state == ST_IDLE) && !ser_busy && win_found;

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (take) state_next = ST_SEND;
      ST_SEND: state_next = ST_WAIT;
      ST_WAIT: begin
        if (!ser_busy) begin
          state_next = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP:  if (gap_cnt == GAP_LAST) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    active    = (state != ST_IDLE);
    if (take) begin
      req_ready = NREQ'(1) << win_idx;
    end
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      ser_sbyte <= 8'h00;
      ser_send  <= 1'b0;
      grant_id  <= GRANT_RST;
      gap_cnt   <= '0;
    end else begin
      ser_send <= take;
      if (take) begin
        ser_sbyte <= req_data[{win_idx, 3'b000} +: 8];
        grant_id  <= win_idx;
      end
      if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + 16'd1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
// Two instances: GAP_CYCLES=0 with LOCK_TIMEOUT=100, and GAP_CYCLES=20.

module tb_uart_tx_arbiter;

  logic        clk100 = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        ser_busy;
  logic [7:0]  ser_sbyte;
  logic        ser_send;
  logic [1:0]  grant_id;
  logic        active;

  logic [3:0]  gvalid;
  logic [3:0]  req_ready_g;
  logic        ser_busy_g;
  logic [7:0]  ser_sbyte_g;
  logic        ser_send_g;
  logic [1:0]  grant_id_g;
  logic        active_g;

  logic        force_busy;
  int          cyc = 0;
  int          bcnt = 0;
  int          bcnt_g = 0;
  logic [3:0]  hs;
  int          hs_count[4];
  int          last_hs_cyc;
  logic [8:0]  srcq[4][$];
  int          log_d[$], log_g[$], log_c[$];
  int          glog_d[$], glog_c[$];
  int          total = 0;
  int          bad = 0;

  uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(0), .LOCK_TIMEOUT(100)) dut (
    .clk100(clk100), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .ser_busy(ser_busy),
    .ser_sbyte(ser_sbyte), .ser_send(ser_send), .grant_id(grant_id), .active(active)
  );

  uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(20), .LOCK_TIMEOUT(100)) dut_g (
    .clk100(clk100), .reset(reset), .req_valid(gvalid), .req_data(32'h23222120),
    .req_last(4'hF), .req_ready(req_ready_g), .ser_busy(ser_busy_g),
    .ser_sbyte(ser_sbyte_g), .ser_send(ser_send_g), .grant_id(grant_id_g), .active(active_g)
  );

  initial forever #5 clk100 = ~clk100;

  always @(posedge clk100) cyc <= cyc + 1;

  // Transmitter model: busy from the strobe cycle for 1050 cycles, not affected by arbiter reset.
  always @(posedge clk100) begin
    if (ser_send) bcnt <= 1049;
    else if (bcnt != 0) bcnt <= bcnt - 1;
    if (ser_send_g) bcnt_g <= 1049;
    else if (bcnt_g != 0) bcnt_g <= bcnt_g - 1;
  end
  assign ser_busy   = ser_send | (bcnt != 0) | force_busy;
  assign ser_busy_g = ser_send_g | (bcnt_g != 0) | force_busy;

  always @(posedge clk100 or posedge reset) begin
    if (reset) hs <= '0;
    else       hs <= req_valid & req_ready;
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk100);
      for (int i = 0; i < 4; i++) begin
        if (hs[i]) begin
          hs_count[i]++;
          last_hs_cyc = cyc;
          if (srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        if (srcq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = srcq[i][0][7:0];
          req_last[i]        = srcq[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk100);
    if (ser_send) begin
      log_d.push_back(int'(ser_sbyte));
      log_g.push_back(int'(grant_id));
      log_c.push_back(cyc);
    end
    if (ser_send_g) begin
      glog_d.push_back(int'(ser_sbyte_g));
      glog_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk100);
    #1;
  endtask

  task automatic wait_sends(input int n, input int budget);
    int b = 0;
    while (log_d.size() < n && b < budget) begin
      step();
      b++;
    end
    chk("send_count", log_d.size(), n);
  endtask

  task automatic do_reset();
    int b = 0;
    while ((bcnt != 0 || bcnt_g != 0) && b < 3000) begin
      step();
      b++;
    end
    for (int i = 0; i < 4; i++) begin
      srcq[i].delete();
      hs_count[i] = 0;
    end
    gvalid = '0;
    force_busy = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    log_d.delete(); log_g.delete(); log_c.delete();
    glog_d.delete(); glog_c.delete();
  endtask

  initial begin
    int s;
    int seen;
    int exp_d[5];
    reset = 1'b1;
    force_busy = 1'b0;
    gvalid = '0;
    step();
    do_reset();

    // Reset values
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_sbyte", int'(ser_sbyte), 0);
    chk("rst_send", int'(ser_send), 0);
    chk("rst_grant", int'(grant_id), 3);
    chk("rst_active", int'(active), 0);

    // Single byte
    srcq[0].push_back({1'b1, 8'h55});
    wait_sends(1, 100);
    chk("single_data", log_d[0], 8'h55);
    chk("single_grant", log_g[0], 0);
    chk("single_latency", log_c[0], last_hs_cyc);
    chk("single_hs_count", hs_count[0], 1);
    repeat (1200) step();
    chk("single_no_more", log_d.size(), 1);

    // Round robin, all requesters valid
    do_reset();
    srcq[0].push_back({1'b1, 8'h10});
    srcq[0].push_back({1'b1, 8'h10});
    srcq[1].push_back({1'b1, 8'h11});
    srcq[2].push_back({1'b1, 8'h12});
    srcq[3].push_back({1'b1, 8'h13});
    wait_sends(5, 6000);
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    for (int k = 0; k < 5 && k < log_d.size(); k++) begin
      chk("rr_data", log_d[k], exp_d[k]);
      chk("rr_grant", log_g[k], k % 4);
      if (k > 0) chk("rr_spacing", log_c[k] - log_c[k-1], 1052);
    end

    // Packet lock
    do_reset();
    srcq[1].push_back({1'b0, 8'hA0});
    srcq[1].push_back({1'b0, 8'hA1});
    srcq[1].push_back({1'b1, 8'hA2});
    srcq[2].push_back({1'b1, 8'hB0});
    wait_sends(4, 6000);
`ifdef UART_ARB_PKTLOCK_EN
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 0};
`else
    exp_d = '{8'hA0, 8'hB0, 8'hA1, 8'hA2, 0};
`endif
    for (int k = 0; k < 4 && k < log_d.size(); k++) chk("lock_data", log_d[k], exp_d[k]);

`ifdef UART_ARB_PKTLOCK_EN
    // Lock timeout: req2 waits LOCK_TIMEOUT idle cycles
    do_reset();
    srcq[1].push_back({1'b0, 8'hA0});
    srcq[2].push_back({1'b1, 8'hB0});
    wait_sends(1, 100);
    chk("to_first", log_d[0], 8'hA0);
    s = log_c[0];
    while (cyc < s + 1150) step();
    chk("to_ready_before", int'(req_ready), 0);
    step();
    chk("to_ready_at", int'(req_ready), 4'b0100);
    wait_sends(2, 300);
    if (log_d.size() >= 2) begin
      chk("to_data", log_d[1], 8'hB0);
      chk("to_grant", log_g[1], 2);
      chk("to_spacing", log_c[1] - s, 1152);
    end
`endif

    // Reset mid-WAIT
    do_reset();
    srcq[0].push_back({1'b1, 8'h33});
    wait_sends(1, 100);
    s = log_c[0];
    while (cyc < s + 300) step();
    chk("mid_active", int'(active), 1);
    reset = 1'b1;
    #1;
    chk("mid_ready", int'(req_ready), 0);
    chk("mid_sbyte", int'(ser_sbyte), 0);
    chk("mid_send", int'(ser_send), 0);
    chk("mid_grant", int'(grant_id), 3);
    chk("mid_active_rst", int'(active), 0);
    step();
    reset = 1'b0;
    log_d.delete(); log_g.delete(); log_c.delete();
    srcq[3].push_back({1'b1, 8'h7E});
    wait_sends(1, 1500);
    if (log_d.size() >= 1) begin
      chk("post_data", log_d[0], 8'h7E);
      chk("post_grant", log_g[0], 3);
    end

    // Gap and busy gating on the GAP_CYCLES=20 instance
    do_reset();
    force_busy = 1'b1;
    gvalid = 4'hF;
    seen = 0;
    repeat (50) begin
      step();
      seen |= int'(req_ready_g);
    end
    chk("gap_busy_ready", seen, 0);
    chk("gap_busy_active", int'(active_g), 0);
    force_busy = 1'b0;
    s = 0;
    while (glog_d.size() < 2 && s < 3000) begin
      step();
      s++;
    end
    chk("gap_send_count", glog_d.size(), 2);
    if (glog_d.size() >= 2) begin
      chk("gap_data0", glog_d[0], 8'h20);
      chk("gap_data1", glog_d[1], 8'h21);
      chk("gap_spacing", glog_c[1] - glog_c[0], 1072);
    end
    gvalid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
